// File: rtl/solo_squash_sequencer_pkg.sv
// Shared state encoding for the solo_squash game-flow sequencer.
package solo_squash_sequencer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE  = 2'd1,
        ST_PLAY   = 2'd2,
        ST_PAUSED = 2'd3
    } state_t;

    localparam int KEY_START = 0;
    localparam int KEY_PAUSE = 1;
    localparam int NUM_KEYS  = 2;

endpackage

// File: rtl/solo_squash_sequencer_debounce.sv
// Frame-rate key debouncer: level flips after FRAMES consecutive disagreeing ticks,
// press pulses once on each released->pressed flip.
module squash_debounce #(
    parameter int FRAMES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw_n,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(FRAMES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (tick) begin
            // level is active-high (1 = pressed); raw is active-low
            if (~raw_n == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(FRAMES - 1)) begin
                level_d = ~level_q;
                cnt_d   = '0;
                press_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/solo_squash_sequencer.sv
// Game-flow controller: vsync-derived frame tick, debounced start/pause keys,
// IDLE/SERVE/PLAY/PAUSED FSM driving the core's new_game_n and pause_n.
module solo_squash_sequencer
    import solo_squash_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int SERVE_FRAMES    = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync_n,
    input  logic       start_key_n,
    input  logic       pause_key_n,
    output logic       new_game_n,
    output logic       pause_n,
    output logic [1:0] state,
    output logic       frame_tick
);
    localparam int SCW = $clog2(SERVE_FRAMES + 1);

    logic                vsync_q, vsync_d;
    logic                frame_tick_q, frame_tick_d;
    state_t              state_q, state_d;
    logic [SCW-1:0]      serve_cnt_q, serve_cnt_d;
    logic                new_game_n_q, new_game_n_d;
    logic                pause_n_q, pause_n_d;

    logic [NUM_KEYS-1:0] key_raw_n;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_level_unused;
    logic                start_press, pause_press;

    assign key_raw_n = {pause_key_n, start_key_n};

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        squash_debounce #(.FRAMES(DEBOUNCE_FRAMES)) u_deb (
            .clk   (clk),
            .reset (reset),
            .tick  (frame_tick_q),
            .raw_n (key_raw_n[g]),
            .level (key_level_unused[g]),
            .press (key_press[g])
        );
    end

    assign start_press = key_press[KEY_START];
    assign pause_press = key_press[KEY_PAUSE];

    always_comb begin
        vsync_d      = vsync_n;
        frame_tick_d = vsync_q & ~vsync_n;
    end

    // State register; outputs and serve counter are registered alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            state_q      <= ST_IDLE;
            serve_cnt_q  <= '0;
            new_game_n_q <= 1'b0;
            pause_n_q    <= 1'b0;
        end else begin
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
            state_q      <= state_d;
            serve_cnt_q  <= serve_cnt_d;
            new_game_n_q <= new_game_n_d;
            pause_n_q    <= pause_n_d;
        end
    end

    // Start press wins over pause press and over serve expiry in every state
    always_comb begin
        state_d = state_q;
        if (start_press) begin
            state_d = ST_SERVE;
        end else begin
            case (state_q)
                ST_SERVE:  if (frame_tick_q && serve_cnt_q == SCW'(1)) state_d = ST_PLAY;
                ST_PLAY:   if (pause_press) state_d = ST_PAUSED;
                ST_PAUSED: if (pause_press) state_d = ST_PLAY;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        serve_cnt_d = serve_cnt_q;
        if (start_press)
            serve_cnt_d = SCW'(SERVE_FRAMES);
        else if (state_q == ST_SERVE && frame_tick_q && serve_cnt_q > SCW'(1))
            serve_cnt_d = serve_cnt_q - 1'b1;
        new_game_n_d = !(state_d == ST_IDLE || start_press);
        pause_n_d    = (state_d == ST_PLAY);
    end

    assign new_game_n = new_game_n_q;
    assign pause_n    = pause_n_q;
    assign state      = state_q;
    assign frame_tick = frame_tick_q;

endmodule
